// File: rtl/tt_check_pkg.sv
// Shared types for the truth-table sweeper: controller states and the default
// settle time applied to each vector before sampling.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_e;

  localparam int SETTLE_DEFAULT = 2;

endpackage

// File: rtl/truth_table_checker_if.sv
// Bundle between the sweeper (slave) and whoever owns the DUT and reads results (master).
// clk/rst are not part of it; they stay plain module ports.
interface truth_table_checker_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_vld;

  modport master (
    output start, dut_out,
    input  vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_vld
  );

  modport slave (
    input  start, dut_out,
    output vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_vld
  );
endinterface

// File: rtl/tt_vec_counter.sv
// Vector register driven onto the DUT inputs; clear has priority over increment,
// and the count saturates at all-ones so a sweep can never wrap back to zero.
module tt_vec_counter #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [N_IN-1:0] vec,
  output logic            is_last
);

  logic [N_IN-1:0] vec_q;
  logic [N_IN-1:0] vec_d;

  assign is_last = &vec_q;
  assign vec     = vec_q;

  always_comb begin
    vec_d = vec_q;
    if (clr) begin
      vec_d = '0;
    end else if (inc && !is_last) begin
      vec_d = vec_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a small combinational DUT, compares its output
// against EXPECTED and reports mismatch count, first failing vector and pass.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int                 N_IN     = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = '0,
  parameter int                 SETTLE   = SETTLE_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_checker_if.slave bus
);

  // Counter must hold SETTLE itself; keep at least one bit when SETTLE is zero.
  localparam int            CW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  state_e          state_q,  state_d;
  logic [CW-1:0]   wcnt_q,   wcnt_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic            pass_q,   pass_d;
  logic [N_IN:0]   err_q,    err_d;
  logic [N_IN-1:0] ffv_q,    ffv_d;
  logic            ffvld_q,  ffvld_d;

  logic            vec_clr;
  logic            vec_inc;
  logic [N_IN-1:0] vec;
  logic            is_last;
  logic            mismatch;

  tt_vec_counter #(.N_IN(N_IN)) u_vec (
    .clk     (clk),
    .rst     (rst),
    .clr     (vec_clr),
    .inc     (vec_inc),
    .vec     (vec),
    .is_last (is_last)
  );

  assign mismatch = (bus.dut_out != EXPECTED[vec]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvld_d = ffvld_q;
    vec_clr = 1'b0;
    vec_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d   = '0;
          ffv_d   = '0;
          ffvld_d = 1'b0;
          pass_d  = 1'b0;
          vec_clr = 1'b1;
          wcnt_d  = SETTLE_LD;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      // Counting down to zero inclusive gives SETTLE+1 wait cycles per vector.
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ffvld_q) begin
            ffv_d   = vec;
            ffvld_d = 1'b1;
          end
        end
        if (is_last) begin
          state_d = DONE;
        end else begin
          vec_inc = 1'b1;
          wcnt_d  = SETTLE_LD;
          state_d = WAIT;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        vec_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvld_q <= ffvld_d;
    end
  end

  assign bus.vec_out        = vec;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.first_fail_vld = ffvld_q;

endmodule
